// File: rtl/fpga_seq_pkg.sv
// Shared types for the front-panel switch sequencer: FSM state encoding,
// switch channel roles and the per-state output decode.
package fpga_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AUTO = 3'd1,
        ARST = 3'd2,
        LOCK = 3'd3,
        RUN  = 3'd4,
        MRST = 3'd5,
        HALT = 3'd6
    } state_e;

    localparam int CH_START = 0;
    localparam int CH_RST   = 1;
    localparam int CH_CLK   = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Packed as {rst_n_auto, reset_n, sw_clk}.
    function automatic logic [2:0] seq_outs(input state_e s);
        logic [2:0] o;
        o = 3'b100;
        case (s)
            IDLE:      o = 3'b100;
            AUTO:      o = 3'b000;
            ARST:      o = 3'b101;
            LOCK, RUN: o = 3'b111;
            MRST:      o = 3'b101;
            HALT:      o = 3'b110;
            default:   o = 3'b100;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser plus stable-count debouncer; level flips
// DEB_CYCLES+2 cycles after a clean raw change. rise_o is the event that the level goes 1 on the coming edge.
module sw_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
            rise_d  = ~level_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_d;

endmodule

// File: rtl/fpga_switch_sequencer.sv
// Front-panel controller: debounced switches drive the ASIC power-up sequencer.
// Sequencer outputs are registered and change on the same edge as the switch rise pulse.
module fpga_switch_sequencer
    import fpga_seq_pkg::*;
#(
    parameter int NUM_SW     = 4,
    parameter int DEB_CYCLES = 16,
    parameter int RST_HOLD   = 20,
    parameter int LOCK_TO    = 64
) (
    input  logic              I_clk_src,
    input  logic              I_rst_n,
    input  logic [NUM_SW-1:0] I_SW,
    input  logic              I_DLL_lock,
    output logic [NUM_SW-1:0] O_sw_level,
    output logic [NUM_SW-1:0] O_sw_rise,
    output logic              O_rst_n_auto,
    output logic              O_reset_n,
    output logic              O_SW_clk,
    output logic              O_lock_err,
    output logic [2:0]        O_state
);
    localparam int PW = $clog2(max_int(RST_HOLD, LOCK_TO) + 1);
    localparam logic [PW-1:0] HOLD_LAST = PW'(RST_HOLD - 1);
    localparam logic [PW-1:0] LOCK_LAST = PW'((LOCK_TO > 0) ? LOCK_TO - 1 : 0);

    logic [NUM_SW-1:0] rise_nxt;
    logic [NUM_SW-1:0] rise_q;
    logic              lock_s1_q, lock_s2_q;
    state_e            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              err_q, err_d;
    logic [2:0]        outs_q;
    logic              restart;
    logic              timed;
    logic              hold_done;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
        sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i   (I_clk_src),
            .rst_ni  (I_rst_n),
            .sw_i    (I_SW[g]),
            .level_o (O_sw_level[g]),
            .rise_o  (rise_nxt[g])
        );
    end

    assign timed     = (state_q == AUTO) || (state_q == ARST) ||
                       (state_q == LOCK) || (state_q == MRST);
    assign hold_done = (phase_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        restart = 1'b0;
        case (state_q)
            AUTO: if (hold_done) state_d = ARST;
            ARST: if (hold_done) state_d = (LOCK_TO == 0) ? RUN : LOCK;
            LOCK: begin
                if (lock_s2_q) begin
                    state_d = RUN;
                end else if (phase_q == LOCK_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            RUN: begin
                if (rise_nxt[CH_RST])      state_d = MRST;
                else if (rise_nxt[CH_CLK]) state_d = HALT;
            end
            MRST: if (hold_done) state_d = RUN;
            HALT: if (rise_nxt[CH_CLK]) state_d = RUN;
            default: state_d = state_q;
        endcase
        // START outranks everything, including a phase already in progress.
        if (rise_nxt[CH_START]) begin
            state_d = AUTO;
            err_d   = 1'b0;
            restart = 1'b1;
        end

        if (restart || (state_d != state_q) || !timed) phase_d = '0;
        else                                           phase_d = phase_q + PW'(1);
    end

    always_ff @(posedge I_clk_src or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
            state_q   <= IDLE;
            phase_q   <= '0;
            err_q     <= 1'b0;
            outs_q    <= seq_outs(IDLE);
            rise_q    <= '0;
        end else begin
            lock_s1_q <= I_DLL_lock;
            lock_s2_q <= lock_s1_q;
            state_q   <= state_d;
            phase_q   <= phase_d;
            err_q     <= err_d;
            outs_q    <= seq_outs(state_d);
            rise_q    <= rise_nxt;
        end
    end

    assign O_sw_rise    = rise_q;
    assign O_rst_n_auto = outs_q[2];
    assign O_reset_n    = outs_q[1];
    assign O_SW_clk     = outs_q[0];
    assign O_lock_err   = err_q;
    assign O_state      = state_q;

endmodule

// File: tb/tb_fpga_switch_sequencer.sv
// Directed bench for the switch sequencer; DEB_CYCLES=16, RST_HOLD=20, LOCK_TO=64.
module tb_fpga_switch_sequencer;
    import fpga_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'b0;
    logic       dll = 1'b0;
    logic [3:0] O_sw_level, O_sw_rise;
    logic       O_rst_n_auto, O_reset_n, O_SW_clk, O_lock_err;
    logic [2:0] O_state;

    int checks = 0;
    int errors = 0;
    int rise0_cnt = 0;
    int first_rise;
    int bad;

    always #5 clk = ~clk;

    fpga_switch_sequencer #(
        .NUM_SW(4), .DEB_CYCLES(16), .RST_HOLD(20), .LOCK_TO(64)
    ) dut (
        .I_clk_src    (clk),
        .I_rst_n      (rst_n),
        .I_SW         (sw),
        .I_DLL_lock   (dll),
        .O_sw_level   (O_sw_level),
        .O_sw_rise    (O_sw_rise),
        .O_rst_n_auto (O_rst_n_auto),
        .O_reset_n    (O_reset_n),
        .O_SW_clk     (O_SW_clk),
        .O_lock_err   (O_lock_err),
        .O_state      (O_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {rst_n_auto, reset_n, sw_clk}
    task automatic check_outs(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, O_rst_n_auto, O_reset_n, O_SW_clk}, {29'd0, exp});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (O_sw_rise[0]) rise0_cnt++;
        end
    endtask

    // Returns on the cycle the rise pulse is visible.
    task automatic sw_pulse(input logic [3:0] m);
        sw = sw | m;
        step(16);
        sw = sw & ~m;
        step(2);
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_state", O_state, IDLE);
        check_outs("rst_outs", 3'b100);
        check("rst_err", O_lock_err, 0);
        check("rst_level", O_sw_level, 0);
        check("rst_rise", O_sw_rise, 0);
        rst_n = 1'b1;
        step(2);
        check("idle_after_rst", O_state, IDLE);

        // Bounce on ch0: 8 segments of 5 cycles, no level change allowed
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            sw[0] = (i % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                step(1);
                if (O_sw_level[0] || O_sw_rise[0]) bad++;
            end
        end
        check("bounce_quiet", bad, 0);

        // Final edge held: rise 18 cycles later, bring-up starts (t=0)
        sw[0] = 1'b1;
        rise0_cnt = 0;
        first_rise = -1;
        for (int c = 1; c <= 18; c++) begin
            step(1);
            if (O_sw_rise[0] && first_rise < 0) first_rise = c;
        end
        check("rise_latency", first_rise, 18);
        check("level_after_rise", O_sw_level[0], 1);
        check("bu_auto", O_state, AUTO);
        check_outs("bu_auto_outs", 3'b000);
        step(12);
        sw[0] = 1'b0;
        step(7);
        check("bu_auto_t19", O_state, AUTO);
        step(1);
        check("bu_arst", O_state, ARST);
        check_outs("bu_arst_outs", 3'b101);
        step(19);
        check_outs("bu_arst_t39", 3'b101);
        step(1);
        check("bu_lock", O_state, LOCK);
        check_outs("bu_lock_outs", 3'b111);
        step(5);
        dll = 1'b1;
        step(2);
        check("bu_lock_wait", O_state, LOCK);
        step(1);
        check("bu_run", O_state, RUN);
        check_outs("bu_run_outs", 3'b111);
        check("single_rise", rise0_cnt, 1);

        // Manual reset; a ch2 rise inside MRST is ignored
        sw_pulse(4'b0010);
        check("mrst", O_state, MRST);
        check_outs("mrst_outs", 3'b101);
        sw_pulse(4'b0100);
        check("mrst_ignore_ch2", O_state, MRST);
        step(1);
        check_outs("mrst_t19", 3'b101);
        step(1);
        check("mrst_back_run", O_state, RUN);
        check_outs("mrst_run_outs", 3'b111);
        step(12);

        // Clock halt and restart
        sw_pulse(4'b0100);
        check("halt", O_state, HALT);
        check_outs("halt_outs", 3'b110);
        step(14);
        sw_pulse(4'b0100);
        check("halt_to_run", O_state, RUN);
        check_outs("halt_run_outs", 3'b111);

        // ch0 and ch1 together in RUN, then lock timeout
        dll = 1'b0;
        step(5);
        sw_pulse(4'b0011);
        check("simul_rises", O_sw_rise[1:0], 2'b11);
        check("simul_auto", O_state, AUTO);
        step(20);
        check("to_arst", O_state, ARST);
        step(20);
        check("to_lock", O_state, LOCK);
        step(63);
        check("to_lock_t63", O_state, LOCK);
        step(1);
        check("to_idle", O_state, IDLE);
        check("to_err", O_lock_err, 1);
        check_outs("to_outs", 3'b100);

        // Next start clears the error; second start aborts ARST
        step(5);
        sw_pulse(4'b0001);
        check("clr_auto", O_state, AUTO);
        check("clr_err", O_lock_err, 0);
        step(14);
        sw_pulse(4'b0001);
        check("abort_auto", O_state, AUTO);
        check_outs("abort_outs", 3'b000);
        step(19);
        check("abort_t19", O_state, AUTO);
        step(1);
        check("abort_arst", O_state, ARST);

        // Asynchronous reset during LOCK
        sw[3] = 1'b1;
        step(20);
        check("ch3_level", O_sw_level[3], 1);
        check("pre_rst_lock", O_state, LOCK);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", O_state, IDLE);
        check_outs("arst_outs", 3'b100);
        check("arst_err", O_lock_err, 0);
        check("arst_level", O_sw_level, 0);
        sw[3] = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_level", O_sw_level, 0);
        check("post_rst_state", O_state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
